cpu_step_ctrl: RTL

//  Run/halt/single-step clock-enable generator upstream of gb_cpu, replacing the free-running divider.

---
 rtl/cpu_step_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/halt/single-step clock-enable generator for the CPU core.
// Debounces the step button and run switch and counts issued enables.
module cpu_step_ctrl #(
    parameter int RUN_DIV   = 25_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_step,
    input  logic        sw_run,
    output logic        cpu_ce,
    output logic        run_led,
    output logic [1:0]  state,
    output logic [15:0] ce_count
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIV - 1);

    // bit 0: step button, bit 1: run switch
    logic [1:0]       raw;
    logic [1:0]       s1_q;
    logic [1:0]       s2_q;
    logic [1:0]       db_q;
    logic [CNT_W-1:0] db_cnt_q [2];

    assign raw = {sw_run, btn_step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            db_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            // A synced value must hold for DB_CYCLES before it is accepted
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= s2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic step_prev_q;
    logic step_req;
    logic run_db;

    assign run_db   = db_q[1];
    assign step_req = db_q[0] & ~step_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= db_q[0];
        end
    end

    state_e           state_q;
    logic [CNT_W-1:0] div_q;
    logic             cpu_ce_q;
    logic             cpu_ce_d;
    logic             run_led_q;
    logic [15:0]      ce_count_q;

    // Leaving RUN suppresses the pulse that would land on the exit cycle
    assign cpu_ce_d = (state_q == S_STEP) ||
                      (state_q == S_RUN && run_db && div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HALT;
            div_q      <= '0;
            cpu_ce_q   <= 1'b0;
            run_led_q  <= 1'b0;
            ce_count_q <= '0;
        end else begin
            cpu_ce_q   <= cpu_ce_d;
            ce_count_q <= ce_count_q + {15'd0, cpu_ce_d};
            unique case (state_q)
                S_HALT: begin
                    div_q <= '0;
                    if (run_db) begin
                        state_q   <= S_RUN;
                        run_led_q <= 1'b1;
                    end else if (step_req) begin
                        state_q <= S_STEP;
                    end
                end
                S_STEP: begin
                    state_q <= S_HALT;
                end
                S_RUN: begin
                    if (!run_db) begin
                        state_q   <= S_HALT;
                        run_led_q <= 1'b0;
                        div_q     <= '0;
                    end else if (div_q == DIV_LAST) begin
                        div_q <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_HALT;
                    run_led_q <= 1'b0;
                    div_q     <= '0;
                end
            endcase
        end
    end

    assign cpu_ce   = cpu_ce_q;
    assign run_led  = run_led_q;
    assign state    = state_q;
    assign ce_count = ce_count_q;

endmodule
